// File: rtl/dmem_controller.sv
// dmem_controller: single-port 32-bit data memory behind a valid/ready
// request/response handshake, with a fixed number of wait states per access.
// Byte, half and word loads/stores are supported.
// Misaligned or illegal accesses answer with rsp_err and leave memory alone.
// Optional feature: define DMEM_ACCESS_CNT_EN to add the saturating
// rd_count/wr_count access counters.
module dmem_controller #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  enter_resp;
    logic                  accept;
    logic [3:0]            wait_cnt;

    logic                  cap_we;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic [1:0]            cap_lane;
    logic [31:0]           cap_wdata;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;

    logic                  acc_we;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [1:0]            acc_lane;
    logic [31:0]           acc_wdata;
    logic [1:0]            acc_size;
    logic                  acc_unsigned;
    logic                  acc_err;

    logic [31:0]           rd_word;
    logic [31:0]           shifted;
    logic [31:0]           load_data;
    logic [31:0]           wr_word;

    logic [31:0]           mem [DEPTH];

    logic                  unused_addr_bits;

    // Address bits above the word index are deliberately ignored (wrap-around).
    assign unused_addr_bits = &{1'b0, req_addr[31:DEPTH_LOG2+2]};

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // Next-state logic; enter_resp marks the edge on which the access happens.
    always_comb begin
        state_next = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge itself,
    // before the capture registers load, so the live request is used then.
    always_comb begin
        acc_we       = cap_we;
        acc_idx      = cap_idx;
        acc_lane     = cap_lane;
        acc_wdata    = cap_wdata;
        acc_size     = cap_size;
        acc_unsigned = cap_unsigned;
        if (state == IDLE) begin
            acc_we       = req_we;
            acc_idx      = req_addr[DEPTH_LOG2+1:2];
            acc_lane     = req_addr[1:0];
            acc_wdata    = req_wdata;
            acc_size     = req_size;
            acc_unsigned = req_unsigned;
        end
        acc_err = (acc_size == 2'b11) ||
                  ((acc_size == 2'b01) && acc_lane[0]) ||
                  ((acc_size == 2'b10) && (acc_lane != 2'b00));
    end

    // Load extraction and store merge on the addressed word.
    always_comb begin
        rd_word   = mem[acc_idx];
        shifted   = rd_word >> {acc_lane, 3'b000};
        load_data = rd_word;
        wr_word   = rd_word;
        case (acc_size)
            2'b00: begin
                load_data = {{24{~acc_unsigned & shifted[7]}}, shifted[7:0]};
                wr_word[{acc_lane, 3'b000} +: 8] = acc_wdata[7:0];
            end
            2'b01: begin
                load_data = {{16{~acc_unsigned & shifted[15]}}, shifted[15:0]};
                wr_word[{acc_lane[1], 4'b0000} +: 16] = acc_wdata[15:0];
            end
            default: begin
                load_data = rd_word;
                wr_word   = acc_wdata;
            end
        endcase
    end

    // Memory array is never cleared; stores land only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && acc_we && !acc_err) begin
            mem[acc_idx] <= wr_word;
        end
    end

    // FSM state, request capture, wait counter and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            cap_we       <= 1'b0;
            cap_idx      <= '0;
            cap_lane     <= 2'b00;
            cap_wdata    <= 32'd0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cap_we       <= req_we;
                cap_idx      <= req_addr[DEPTH_LOG2+1:2];
                cap_lane     <= req_addr[1:0];
                cap_wdata    <= req_wdata;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
            end
            if (accept && (WAIT_STATES != 0)) begin
                wait_cnt <= 4'(WAIT_STATES - 1);
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_rdata <= (acc_we || acc_err) ? 32'd0 : load_data;
                rsp_err   <= acc_err;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    // Saturating counters of successful loads and stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (enter_resp && !acc_err) begin
            if (acc_we && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end else if (!acc_we && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_controller.sv
// tb_dmem_controller: directed vectors for dmem_controller.
// Instance 0 uses default parameters, instance 1 has WAIT_STATES=0 and
// instance 2 has WAIT_STATES=3.
// Counter checks are compiled in when DMEM_ACCESS_CNT_EN is defined.
module tb_dmem_controller;

    logic        clk = 1'b0;
    logic [2:0]  reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [1:0]  req_size  [3];
    logic [2:0]  req_unsigned;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [31:0] rsp_rdata [3];
    logic [2:0]  rsp_err;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count [3];
    logic [15:0] wr_count [3];
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_controller #(
            .DEPTH_LOG2 (8),
            .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk         (clk),
            .reset       (reset[g]),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_we      (req_we[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .req_size    (req_size[g]),
            .req_unsigned(req_unsigned[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_rdata   (rsp_rdata[g]),
            .rsp_err     (rsp_err[g])
`ifdef DMEM_ACCESS_CNT_EN
            ,
            .rd_count    (rd_count[g]),
            .wr_count    (wr_count[g])
`endif
        );
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [25];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check_output({tag, " req_ready"}, {31'd0, req_ready[d]}, 32'd1);
        check_output({tag, " rsp_valid"}, {31'd0, rsp_valid[d]}, 32'd0);
        check_output({tag, " rsp_rdata"}, rsp_rdata[d], 32'd0);
        check_output({tag, " rsp_err"},   {31'd0, rsp_err[d]},   32'd0);
    endtask

    // Wait (bounded) for rsp_valid; returns cycles since the acceptance edge.
    task automatic wait_rsp(input int d, output int lat);
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One full transaction; request inputs are scrambled after acceptance.
    task automatic apply_stimulus(input int d, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [1:0] size,
                                  input logic uns, output logic [31:0] rdata,
                                  output logic err, output int lat);
        @(negedge clk);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        rsp_ready[d]    = 1'b0;
        @(posedge clk);
        #1;
        req_valid[d]    = 1'b0;
        req_we[d]       = ~we;
        req_addr[d]     = ~addr;
        req_wdata[d]    = ~wdata;
        req_size[d]     = ~size;
        req_unsigned[d] = ~uns;
        wait_rsp(d, lat);
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic run_check(input int d, input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                             input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        apply_stimulus(d, we, addr, wdata, size, uns, rdata, err, lat);
        check_output({tag, " rdata"},   rdata,          exp_rdata);
        check_output({tag, " err"},     {31'd0, err},   {31'd0, exp_err});
        check_output({tag, " latency"}, 32'(lat),       32'(exp_lat));
    endtask

    initial begin
        int lat;
        int exp_rd;
        int exp_wr;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'h1234_5680, 2'b00, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 2'b00, 1'b1, 32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 2'b10, 1'b0, 32'h80AD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0011, 32'h0000_0000, 2'b01, 1'b0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 2'b10, 1'b0, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 2'b11, 1'b0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h0000_0000, 2'b11, 1'b0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_0011, 32'h0000_0000, 2'b01, 1'b0, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_0012, 32'h0000_0000, 2'b10, 1'b0, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 2'b10, 1'b0, 32'h80AD_BEEF, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0014, 32'h1122_3344, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, 32'h0000_0016, 32'hABCD_8765, 2'b01, 1'b0, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0016, 32'h0000_0000, 2'b01, 1'b0, 32'hFFFF_8765, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 2'b01, 1'b1, 32'h0000_3344, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_0015, 32'h0000_0000, 2'b00, 1'b0, 32'h0000_0033, 1'b0};
        vecs[18] = '{1'b0, 32'h0000_0017, 32'h0000_0000, 2'b00, 1'b0, 32'hFFFF_FF87, 1'b0};
        vecs[19] = '{1'b1, 32'h0000_0420, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
        vecs[20] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[21] = '{1'b1, 32'hFFFF_0020, 32'h0000_0055, 2'b00, 1'b0, 32'h0000_0000, 1'b0};
        vecs[22] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 2'b10, 1'b0, 32'hCAFE_F055, 1'b0};
        vecs[23] = '{1'b0, 32'h0000_0012, 32'h0000_0000, 2'b01, 1'b0, 32'hFFFF_80AD, 1'b0};
        vecs[24] = '{1'b0, 32'h0000_0012, 32'h0000_0000, 2'b01, 1'b1, 32'h0000_80AD, 1'b0};

        reset        = 3'b000;
        req_valid    = 3'b000;
        rsp_ready    = 3'b000;
        req_we       = 3'b000;
        req_unsigned = 3'b000;
        for (int d = 0; d < 3; d++) begin
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_size[d]  = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_idle_outputs(d, $sformatf("reset%0d", d));
        end
        @(negedge clk);
        reset = 3'b111;

        // Main table on the default-parameter instance: 3-cycle latency.
        exp_rd = 0;
        exp_wr = 0;
        for (int i = 0; i < 25; i++) begin
            run_check(0, $sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].size, vecs[i].uns, vecs[i].exp_rdata, vecs[i].exp_err, 3);
            if (!vecs[i].exp_err) begin
                if (vecs[i].we) exp_wr++;
                else            exp_rd++;
            end
        end
`ifdef DMEM_ACCESS_CNT_EN
        check_output("rd_count", {16'd0, rd_count[0]}, 32'(exp_rd));
        check_output("wr_count", {16'd0, wr_count[0]}, 32'(exp_wr));
`endif

        // Back-pressure: response held 5 cycles, a store kept pending meanwhile.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h0000_0010;
        req_size[0]  = 2'b10;
        @(posedge clk);
        #1;
        req_we[0]    = 1'b1;
        req_wdata[0] = 32'h0000_0000;
        wait_rsp(0, lat);
        check_output("bp latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            check_output($sformatf("bp%0d rsp_valid", c), {31'd0, rsp_valid[0]}, 32'd1);
            check_output($sformatf("bp%0d rdata", c),     rsp_rdata[0],          32'h80AD_BEEF);
            check_output($sformatf("bp%0d req_ready", c), {31'd0, req_ready[0]}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b0;
        check_output("bp after rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check_output("bp after req_ready", {31'd0, req_ready[0]}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_output("bp single response", {31'd0, rsp_valid[0]}, 32'd0);
        run_check(0, "bp reload", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'h80AD_BEEF, 1'b0, 3);

        // Zero wait states: one-cycle latency for legal and error accesses.
        run_check(1, "ws0 store", 1'b1, 32'h8, 32'h0000_1234, 2'b10, 1'b0, 32'd0, 1'b0, 1);
        run_check(1, "ws0 load",  1'b0, 32'h8, 32'd0, 2'b10, 1'b0, 32'h0000_1234, 1'b0, 1);
        run_check(1, "ws0 err",   1'b0, 32'h9, 32'd0, 2'b01, 1'b0, 32'd0, 1'b1, 1);

        // Three wait states; reset pulse while a store sits in WAIT.
        run_check(2, "ws3 store", 1'b1, 32'h30, 32'h1111_1111, 2'b10, 1'b0, 32'd0, 1'b0, 4);
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h30;
        req_wdata[2] = 32'h9999_9999;
        req_size[2]  = 2'b10;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        reset[2] = 1'b0;
        #1;
        check_idle_outputs(2, "abort");
        @(posedge clk);
        #1;
        check_idle_outputs(2, "abort hold");
        @(negedge clk);
        reset[2] = 1'b1;
        run_check(2, "abort load", 1'b0, 32'h30, 32'd0, 2'b10, 1'b0, 32'h1111_1111, 1'b0, 4);

        // Reset while in RESP: response dropped, completed store kept.
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h34;
        req_wdata[2] = 32'h2222_2222;
        req_size[2]  = 2'b10;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        wait_rsp(2, lat);
        check_output("resp-reset latency", 32'(lat), 32'd4);
        reset[2] = 1'b0;
        #1;
        check_idle_outputs(2, "resp-reset");
        @(negedge clk);
        reset[2] = 1'b1;
        run_check(2, "resp-reset load", 1'b0, 32'h34, 32'd0, 2'b10, 1'b0, 32'h2222_2222, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_controller.md
DMEM_CONTROLLER -- requirements
Module: dmem_controller

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8: log2 of the number of 32-bit words in the memory.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2: extra cycles from request acceptance to access completion (range 0-15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 rsp_err  output  1  access was misaligned or illegal.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 On req_valid && req_ready, the block SHALL capture we, addr, wdata, size and unsigned.
REQ-019 On that same acceptance, the FSM SHALL go to WAIT if WAIT_STATES > 0, otherwise to RESP.
REQ-020 The wait counter SHALL load WAIT_STATES-1 on entry to WAIT and decrement each cycle.
REQ-021 When the counter is 0 in WAIT, the FSM SHALL go to RESP.
REQ-022 The memory access (store or load capture) SHALL occur on the edge that enters RESP.
REQ-023 rsp_valid SHALL first be high WAIT_STATES+1 cycles after the acceptance edge.
REQ-024 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_err SHALL hold stable until rsp_valid && rsp_ready.
REQ-025 On rsp_valid && rsp_ready, the FSM SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-026 The word index SHALL be req_addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so out-of-range addresses wrap modulo the depth.
REQ-027 Byte store SHALL write lane addr[1:0] with wdata[7:0]; half store SHALL write lanes addr[1]*2 and +1 with wdata[15:0]; word store SHALL write all lanes; other lanes are unchanged.
REQ-028 Loads SHALL select the addressed byte or half and extend it per req_unsigned; word loads return the word unmodified.
REQ-029 An access is an error when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
REQ-030 An error access SHALL set rsp_err=1 and rsp_rdata=0, SHALL NOT modify memory, and SHALL have the same latency as a legal access.
REQ-031 Inputs other than req_valid SHALL be ignored outside the acceptance cycle.

Reset
REQ-032 While reset=0, the FSM SHALL be in IDLE, and req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the wait counter=0.
REQ-033 Reset asserted in WAIT SHALL abort the request; a pending store SHALL NOT be performed.
REQ-034 Reset asserted in RESP SHALL drop the response; a store already performed SHALL remain.
REQ-035 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-036 With macro DMEM_ACCESS_CNT_EN defined, the block SHALL add outputs rd_count[15:0] and wr_count[15:0].
REQ-037 With DMEM_ACCESS_CNT_EN, each counter SHALL increment on entry to RESP for a non-error load or store respectively, saturate at 16'hFFFF, and reset to 0.
REQ-038 Without DMEM_ACCESS_CNT_EN, rd_count and wr_count and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-039 Default parameters, store word 0xDEADBEEF at 0x10, then load word 0x10 -> rsp_valid 3 cycles after each acceptance; rdata=0xDEADBEEF; err=0.
REQ-040 Store byte 0x80 at 0x13, then load byte signed and unsigned at 0x13 -> 0xFFFFFF80 and 0x00000080; load word 0x10 -> 0x80ADBEEF.
REQ-041 Load half at 0x11, load word at 0x12, size=11 at 0x0 -> each err=1, rdata=0, memory unchanged, same latency.
REQ-042 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable; req_ready=0 throughout; one response only.
REQ-043 WAIT_STATES=0 -> rsp_valid 1 cycle after acceptance; reset pulse in WAIT during a store (WAIT_STATES=3) -> target word unchanged, outputs at reset values.
REQ-044 DMEM_ACCESS_CNT_EN defined, 3 loads, 2 stores and 1 error -> rd_count=3, wr_count=2.
